usb_tx_serializer: RTL and testbench

- Bit-level transmit stage that sits directly downstream of the USB TX byte encoder.
- Consumes one byte at a time on `shift_data`/`is_eop` and serializes it LSB-first at `CLKS_PER_BIT` clocks per bit, with bit stuffing and NRZI encoding.
- Drives `dplus_out`/`dminus_out` and returns `rollover_flag`, which paces the encoder's byte sequencing.
- Generates EOP signalling (SE0, SE0, J) when the loaded byte is flagged as EOP.

---
 rtl/usb_tx_serializer.sv | 175 +++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_serializer.sv
// USB bit-level transmitter: serializes bytes LSB-first with bit stuffing and NRZI
// line coding, then ends the packet with SE0, SE0, J.
module usb_tx_serializer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       begin_packet,
  input  logic [7:0] shift_data,
  input  logic       is_eop,
  output logic       rollover_flag,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_STROBE = TW'(CLKS_PER_BIT - 1);
  // Set one clock early so the registered pulse lands on timer == CLKS_PER_BIT-2.
  localparam logic [TW-1:0] T_ROLL_SET = TW'(CLKS_PER_BIT - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bit_cnt_q;
  logic [2:0]      ones_q;
  logic            stuff_q;
  logic [7:0]      shift_q;
  logic            rollover_q;
  logic            dp_q;
  logic            dm_q;
  logic            busy_q;

  logic strobe;
  logic cur_bit;
  logic stuff_next;
  logic last_win;

  // During a stuff window bit_cnt_q still points at the data bit that preceded it.
  always_comb begin
    strobe     = (timer_q == T_STROBE);
    cur_bit    = shift_q[bit_cnt_q];
    stuff_next = !stuff_q && cur_bit && (ones_q == 3'd5);
    last_win   = (bit_cnt_q == 3'd7) && !stuff_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      ones_q     <= '0;
      stuff_q    <= 1'b0;
      shift_q    <= '0;
      rollover_q <= 1'b0;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rollover_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          dp_q    <= 1'b1;
          dm_q    <= 1'b0;
          if (begin_packet) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end

        S_LOAD: begin
          shift_q   <= shift_data;
          ones_q    <= '0;
          bit_cnt_q <= '0;
          stuff_q   <= 1'b0;
          timer_q   <= '0;
          if (is_eop) begin
            state_q <= S_EOP_SE0;
            dp_q    <= 1'b0;
            dm_q    <= 1'b0;
          end else begin
            // Line starts at J; a leading 0 toggles it to K.
            state_q <= S_SEND;
            dp_q    <= shift_data[0];
            dm_q    <= ~shift_data[0];
          end
        end

        S_SEND: begin
          timer_q <= strobe ? '0 : timer_q + TW'(1);
          if (last_win && (timer_q == T_ROLL_SET)) begin
            rollover_q <= 1'b1;
          end
          if (strobe) begin
            if (stuff_next) begin
              stuff_q <= 1'b1;
              ones_q  <= '0;
              dp_q    <= ~dp_q;
              dm_q    <= ~dm_q;
            end else begin
              stuff_q <= 1'b0;
              if (stuff_q) begin
                ones_q <= '0;
              end else begin
                ones_q <= cur_bit ? ones_q + 3'd1 : 3'd0;
              end
              if (bit_cnt_q == 3'd7) begin
                shift_q   <= shift_data;
                bit_cnt_q <= '0;
                if (is_eop) begin
                  state_q <= S_EOP_SE0;
                  dp_q    <= 1'b0;
                  dm_q    <= 1'b0;
                end else if (!shift_data[0]) begin
                  dp_q <= ~dp_q;
                  dm_q <= ~dm_q;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (!shift_q[bit_cnt_q + 3'd1]) begin
                  dp_q <= ~dp_q;
                  dm_q <= ~dm_q;
                end
              end
            end
          end
        end

        S_EOP_SE0: begin
          timer_q <= strobe ? '0 : timer_q + TW'(1);
          if (strobe) begin
            if (bit_cnt_q == 3'd1) begin
              state_q   <= S_EOP_J;
              bit_cnt_q <= '0;
              dp_q      <= 1'b1;
              dm_q      <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        S_EOP_J: begin
          timer_q <= strobe ? '0 : timer_q + TW'(1);
          if (strobe) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            timer_q <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          dp_q    <= 1'b1;
          dm_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rollover_flag = rollover_q;
  assign dplus_out     = dp_q;
  assign dminus_out    = dm_q;
  assign tx_busy       = busy_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Randomized bench for usb_tx_serializer: a bit-list model builds the expected
// per-cycle line, rollover and busy trace of each packet.
`timescale 1ns/1ps
module tb_usb_tx_serializer;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       begin_packet = 1'b0;
  logic [7:0] shift_data = 8'h00;
  logic       is_eop = 1'b0;
  logic       rollover_flag;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_busy;

  always #5 clk = ~clk;

  usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .begin_packet (begin_packet),
    .shift_data   (shift_data),
    .is_eop       (is_eop),
    .rollover_flag(rollover_flag),
    .dplus_out    (dplus_out),
    .dminus_out   (dminus_out),
    .tx_busy      (tx_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pkt_q[$];
  logic [3:0] exp_q[$];   // {dp, dm, rollover, busy} per cycle, cycle 0 = begin_packet cycle
  int         samp_q[$];  // cycle whose closing edge samples byte k (k == size: EOP marker)
  int         obs_ro_q[$];
  int         busy_fall;
  int         se0_cnt;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int ro_at(input int i);
    return (i < obs_ro_q.size()) ? obs_ro_q[i] : -1000;
  endfunction

  // Expand bytes into a list of transmitted bits (with stuff zeros), then NRZI-code them.
  task automatic build_model();
    logic       dp;
    int         ones;
    logic [7:0] byt;
    logic [3:0] v;
    int         last;
    exp_q.delete();
    samp_q.delete();
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1001);
    samp_q.push_back(1);
    dp = 1'b1;
    ones = 0;
    foreach (pkt_q[i]) begin
      byt = pkt_q[i];
      for (int b = 0; b < 8; b++) begin
        if (byt[b]) ones++;
        else begin
          dp = ~dp;
          ones = 0;
        end
        for (int t = 0; t < CPB; t++) exp_q.push_back({dp, ~dp, 2'b01});
        if (ones == 6) begin
          dp = ~dp;
          ones = 0;
          for (int t = 0; t < CPB; t++) exp_q.push_back({dp, ~dp, 2'b01});
        end
      end
      last = exp_q.size() - 1;
      v = exp_q[last - 1];
      v[1] = 1'b1;
      exp_q[last - 1] = v;
      samp_q.push_back(last);
    end
    for (int t = 0; t < 2 * CPB; t++) exp_q.push_back(4'b0001);
    for (int t = 0; t < CPB; t++) exp_q.push_back(4'b1001);
    for (int t = 0; t < 4; t++) exp_q.push_back(4'b1000);
  endtask

  task automatic run_packet(input bit noisy, input string name);
    logic [3:0] obs;
    bit         stop;
    int         k;
    int         last_busy;
    build_model();
    obs_ro_q.delete();
    busy_fall = -1;
    se0_cnt = 0;
    stop = 1'b0;
    last_busy = exp_q.size() - 5;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      obs = {dplus_out, dminus_out, rollover_flag, tx_busy};
      if (!stop) begin
        n_tests++;
        if (obs !== exp_q[c]) begin
          n_fail++;
          stop = 1'b1;
          $display("FAIL %s cycle %0d: dp,dm,ro,busy got %b expected %b", name, c, obs, exp_q[c]);
        end
      end
      if (rollover_flag === 1'b1) obs_ro_q.push_back(c);
      if (c > 1 && tx_busy === 1'b0 && busy_fall < 0) busy_fall = c;
      if (tx_busy === 1'b1 && dplus_out === 1'b0 && dminus_out === 1'b0) se0_cnt++;
      k = -1;
      foreach (samp_q[j]) if (samp_q[j] == c) k = j;
      if (k >= 0 && k < pkt_q.size()) begin
        shift_data = pkt_q[k];
        is_eop = 1'b0;
      end else if (k >= 0) begin
        shift_data = 8'($urandom);
        is_eop = 1'b1;
      end else begin
        shift_data = 8'($urandom);
        is_eop = 1'($urandom);
      end
      if (c == 0) begin_packet = 1'b1;
      else if (noisy && c >= 2 && c <= last_busy) begin_packet = ($urandom_range(0, 3) == 0);
      else begin_packet = 1'b0;
    end
    begin_packet = 1'b0;
    $display("[TB] %s: %0d bytes, %0d cycles, %0d rollovers, busy fell at %0d",
             name, pkt_q.size(), exp_q.size(), obs_ro_q.size(), busy_fall);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    n_rst = 1'b0;
    @(negedge clk);
    obs = {dplus_out, dminus_out, rollover_flag, tx_busy};
    n_tests++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_init: got %b expected 1000", obs);
    end
    n_rst = 1'b1;
    @(negedge clk);
    begin_packet = 1'b1;
    shift_data = 8'h80;
    is_eop = 1'b0;
    @(negedge clk);
    begin_packet = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      shift_data = 8'hFF;
    end
    n_tests++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prebusy: tx_busy got %b expected 1", tx_busy);
    end
    n_rst = 1'b0;
    #1;
    obs = {dplus_out, dminus_out, rollover_flag, tx_busy};
    n_tests++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_midrun: got %b expected 1000", obs);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      obs = {dplus_out, dminus_out, rollover_flag, tx_busy};
      n_tests++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b expected 1000", i, obs);
      end
    end
    $display("[TB] reset: mid-packet reset returned line to J and idle");
  endtask

  task automatic test_sync();
    pkt_q = '{8'h80};
    run_packet(1'b0, "sync");
    n_tests++;
    if (obs_ro_q.size() != 1 || ro_at(0) != 64) begin
      n_fail++;
      $display("FAIL sync_rollover: got %0d pulses first at %0d expected 1 at 64",
               obs_ro_q.size(), ro_at(0));
    end
  endtask

  task automatic test_stuff_boundary();
    pkt_q = '{8'h80, 8'hFF};
    run_packet(1'b0, "stuff_ff");
    n_tests++;
    if (ro_at(1) - ro_at(0) != 72) begin
      n_fail++;
      $display("FAIL stuff_ff_gap: got %0d expected 72", ro_at(1) - ro_at(0));
    end
    pkt_q = '{8'h80, 8'h00, 8'hFC};
    run_packet(1'b0, "stuff_last");
    n_tests++;
    if (ro_at(2) - ro_at(1) != 72) begin
      n_fail++;
      $display("FAIL stuff_last_gap: got %0d expected 72", ro_at(2) - ro_at(1));
    end
  endtask

  task automatic test_no_stuff();
    pkt_q = '{8'h80, 8'h00, 8'h1F};
    run_packet(1'b0, "no_stuff");
    n_tests++;
    if (ro_at(2) - ro_at(1) != 64) begin
      n_fail++;
      $display("FAIL no_stuff_gap: got %0d expected 64", ro_at(2) - ro_at(1));
    end
  endtask

  task automatic test_eop();
    pkt_q = '{8'h80};
    run_packet(1'b0, "eop_sync");
    n_tests++;
    if (busy_fall != 90 || se0_cnt != 2 * CPB) begin
      n_fail++;
      $display("FAIL eop_sync: busy fell at %0d se0 %0d clocks, expected 90 and 16", busy_fall, se0_cnt);
    end
    pkt_q = '{8'h80, 8'hFF};
    run_packet(1'b0, "eop_stuffed");
    n_tests++;
    if (busy_fall != 162 || obs_ro_q.size() != 2) begin
      n_fail++;
      $display("FAIL eop_stuffed: busy fell at %0d with %0d pulses, expected 162 and 2",
               busy_fall, obs_ro_q.size());
    end
  endtask

  task automatic test_busy_pulse();
    pkt_q = '{8'h80, 8'h55, 8'hFF};
    run_packet(1'b1, "busy_pulse");
    n_tests++;
    if (obs_ro_q.size() != 3) begin
      n_fail++;
      $display("FAIL busy_pulse_count: got %0d pulses expected 3", obs_ro_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] pick[5] = '{8'hFF, 8'hFE, 8'h7F, 8'hFC, 8'h3F};
    int nb;
    for (int p = 0; p < 25; p++) begin
      pkt_q.delete();
      pkt_q.push_back(8'h80);
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 1) == 0) pkt_q.push_back(8'($urandom));
        else pkt_q.push_back(pick[$urandom_range(0, 4)]);
      end
      run_packet(1'($urandom), $sformatf("random_%0d", p));
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuff_boundary();
    test_no_stuff();
    test_eop();
    test_busy_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
